// File: rtl/tc_pkg.sv
// rtl/tc_pkg.sv - shared types and constants for the tile-controller scheduler
// The entry layout is tied to TC_ADDR_WIDTH and TC_DATA_WIDTH.
package tc_pkg;

  localparam int TC_ADDR_WIDTH = 64;
  localparam int TC_DATA_WIDTH = 512;
  localparam int LINE_BYTES    = TC_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_REQ,
    ST_FETCH_WAIT,
    ST_PF_RUN,
    ST_SIMD_DISP,
    ST_DRAIN,
    ST_DONE
  } tc_state_e;

  // Packed MSB-first, so pf_ptr occupies the lowest bits of the line.
  typedef struct packed {
    logic [TC_ADDR_WIDTH-1:0] l_arg;
    logic [TC_ADDR_WIDTH-1:0] g_arg;
    logic [TC_ADDR_WIDTH-1:0] simd_ptr;
    logic [TC_ADDR_WIDTH-1:0] pf_ptr;
  } entry_t;

  function automatic entry_t tc_extract(input logic [TC_DATA_WIDTH-1:0] line);
    return entry_t'(line[4*TC_ADDR_WIDTH-1:0]);
  endfunction

endpackage

// File: rtl/tc_sched_fsm_if.sv
// rtl/tc_sched_fsm_if.sv - MRA request/response port between scheduler and memory
// master is the scheduler side, slave the memory side.
interface tc_sched_fsm_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512
);
  logic [ADDR_WIDTH-1:0] MRA_req_addr;
  logic                  MRA_rw;
  logic                  MRA_req_valid;
  logic                  MRA_ready;
  logic [DATA_WIDTH-1:0] MRA_rsp_data;
  logic                  MRA_rsp_valid;

  modport master (
    output MRA_req_addr, MRA_rw, MRA_req_valid,
    input  MRA_ready, MRA_rsp_data, MRA_rsp_valid
  );

  modport slave (
    input  MRA_req_addr, MRA_rw, MRA_req_valid,
    output MRA_ready, MRA_rsp_data, MRA_rsp_valid
  );
endinterface

// File: rtl/tc_lane_arb.sv
// rtl/tc_lane_arb.sv - round-robin picker of the first free SIMD lane at or after rr
module tc_lane_arb #(
  parameter int NUM_SIMD = 4,
  parameter int RR_W     = 2
) (
  input  logic [NUM_SIMD-1:0] i_busy,
  input  logic [RR_W-1:0]     i_rr,
  output logic                o_grant_vld,
  output logic [RR_W-1:0]     o_grant_idx
);
  int lane;

  // Scan from the farthest offset back to rr so the nearest free lane wins.
  always_comb begin
    o_grant_vld = 1'b0;
    o_grant_idx = '0;
    lane        = 0;
    for (int off = NUM_SIMD - 1; off >= 0; off--) begin
      lane = (int'(i_rr) + off) % NUM_SIMD;
      if (!i_busy[RR_W'(lane)]) begin
        o_grant_vld = 1'b1;
        o_grant_idx = RR_W'(lane);
      end
    end
  end
endmodule

// File: rtl/tc_sched_fsm.sv
// rtl/tc_sched_fsm.sv - work-list scheduler: MRA fetch, PF prefetch, SIMD lane dispatch
// Optional TC_SCHED_PERF_EN adds saturating busy/entry/stall counters.
module tc_sched_fsm
  import tc_pkg::*;
#(
  parameter int ADDR_WIDTH  = TC_ADDR_WIDTH,
  parameter int DATA_WIDTH  = TC_DATA_WIDTH,
  parameter int WL_LEN_BITS = 8,
  parameter int NUM_SIMD    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  tc_sched_fsm_if.master                 mra,
  output logic [ADDR_WIDTH-1:0]          PF_pointer,
  output logic                           PF_reset,
  input  logic                           PF_done,
  output logic [NUM_SIMD*ADDR_WIDTH-1:0] SIMD_pointer,
  output logic [NUM_SIMD*ADDR_WIDTH-1:0] SIMD_g_arg_pointer,
  output logic [NUM_SIMD*ADDR_WIDTH-1:0] SIMD_l_arg_pointer,
  output logic [NUM_SIMD-1:0]            SIMD_reset,
  input  logic [NUM_SIMD-1:0]            SIMD_done,
  input  logic                           SN_next_op,
  input  logic [ADDR_WIDTH-1:0]          SN_next_addr,
  input  logic [WL_LEN_BITS-1:0]         SN_next_len,
  output logic                           SN_clr_next,
  output logic                           SN_req_done
`ifdef TC_SCHED_PERF_EN
  ,
  output logic [31:0]                    perf_busy_cycles,
  output logic [31:0]                    perf_entries,
  output logic [31:0]                    perf_stall_cycles
`endif
);
  localparam int RR_W = (NUM_SIMD > 1) ? $clog2(NUM_SIMD) : 1;

  tc_state_e              r_state;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [WL_LEN_BITS-1:0] r_len;
  logic [WL_LEN_BITS-1:0] r_idx;
  entry_t                 r_entry;
  logic [NUM_SIMD-1:0]    r_busy;
  logic [NUM_SIMD-1:0]    r_simd_reset;
  logic [RR_W-1:0]        r_rr;
  logic                   r_req_valid;
  logic [ADDR_WIDTH-1:0]  r_req_addr;
  logic [ADDR_WIDTH-1:0]  r_pf_ptr;
  logic                   r_pf_reset;
  logic [ADDR_WIDTH-1:0]  r_simd_ptr [NUM_SIMD];
  logic [ADDR_WIDTH-1:0]  r_g_ptr    [NUM_SIMD];
  logic [ADDR_WIDTH-1:0]  r_l_ptr    [NUM_SIMD];
  logic                   r_clr;
  logic                   r_done;

  logic [DATA_WIDTH-1:0]  w_line;
  entry_t                 w_rsp_entry;
  entry_t                 w_disp_entry;
  logic                   w_grant_vld;
  logic [RR_W-1:0]        w_grant_idx;
  logic                   w_dispatch;
  logic [NUM_SIMD-1:0]    w_grant_mask;
  logic [NUM_SIMD-1:0]    w_done_clr;
  logic [WL_LEN_BITS-1:0] w_idx_nxt;

  tc_lane_arb #(.NUM_SIMD(NUM_SIMD), .RR_W(RR_W)) u_arb (
    .i_busy      (r_busy),
    .i_rr        (r_rr),
    .o_grant_vld (w_grant_vld),
    .o_grant_idx (w_grant_idx)
  );

  assign w_line      = mra.MRA_rsp_data;
  assign w_rsp_entry = tc_extract(w_line);
  // A PF-less entry is dispatched straight from the response when a lane is free.
  assign w_dispatch  = w_grant_vld &&
                       ((r_state == ST_SIMD_DISP) ||
                        (r_state == ST_FETCH_WAIT && mra.MRA_rsp_valid && w_rsp_entry.pf_ptr == '0));
  assign w_disp_entry = (r_state == ST_FETCH_WAIT) ? w_rsp_entry : r_entry;
  assign w_grant_mask = w_dispatch ? (NUM_SIMD'(1) << w_grant_idx) : '0;
  assign w_done_clr   = r_busy & SIMD_done;
  assign w_idx_nxt    = r_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_len        <= '0;
      r_idx        <= '0;
      r_entry      <= '0;
      r_busy       <= '0;
      r_simd_reset <= '1;
      r_rr         <= '0;
      r_req_valid  <= 1'b0;
      r_req_addr   <= '0;
      r_pf_ptr     <= '0;
      r_pf_reset   <= 1'b1;
      r_simd_ptr   <= '{default: '0};
      r_g_ptr      <= '{default: '0};
      r_l_ptr      <= '{default: '0};
      r_clr        <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_clr        <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= (r_busy & ~w_done_clr) | w_grant_mask;
      r_simd_reset <= (r_simd_reset | w_done_clr) & ~w_grant_mask;
      if (w_dispatch) begin
        r_simd_ptr[w_grant_idx] <= w_disp_entry.simd_ptr;
        r_g_ptr[w_grant_idx]    <= w_disp_entry.g_arg;
        r_l_ptr[w_grant_idx]    <= w_disp_entry.l_arg;
        r_rr    <= (w_grant_idx == RR_W'(NUM_SIMD - 1)) ? '0 : w_grant_idx + 1'b1;
        r_idx   <= w_idx_nxt;
        r_addr  <= r_addr + ADDR_WIDTH'(LINE_BYTES);
        r_state <= (w_idx_nxt == r_len) ? ST_DRAIN : ST_FETCH_REQ;
      end
      case (r_state)
        ST_IDLE: if (SN_next_op) begin
          r_addr  <= SN_next_addr;
          r_len   <= SN_next_len;
          r_idx   <= '0;
          r_clr   <= 1'b1;
          r_state <= (SN_next_len == '0) ? ST_DRAIN : ST_FETCH_REQ;
        end
        ST_FETCH_REQ: begin
          if (!r_req_valid) begin
            r_req_valid <= 1'b1;
            r_req_addr  <= r_addr;
          end else if (mra.MRA_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= ST_FETCH_WAIT;
          end
        end
        ST_FETCH_WAIT: if (mra.MRA_rsp_valid) begin
          r_entry <= w_rsp_entry;
          if (w_rsp_entry.pf_ptr != '0) begin
            r_pf_ptr   <= w_rsp_entry.pf_ptr;
            r_pf_reset <= 1'b0;
            r_state    <= ST_PF_RUN;
          end else if (!w_grant_vld) begin
            r_state <= ST_SIMD_DISP;
          end
        end
        ST_PF_RUN: if (!r_pf_reset && PF_done) begin
          r_pf_reset <= 1'b1;
          r_state    <= ST_SIMD_DISP;
        end
        ST_SIMD_DISP: ;
        ST_DRAIN: if (r_busy == '0) r_state <= ST_DONE;
        ST_DONE: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mra.MRA_req_addr  = r_req_addr;
  assign mra.MRA_rw        = 1'b0;
  assign mra.MRA_req_valid = r_req_valid;
  assign PF_pointer        = r_pf_ptr;
  assign PF_reset          = r_pf_reset;
  assign SIMD_reset        = r_simd_reset;
  assign SN_clr_next       = r_clr;
  assign SN_req_done       = r_done;

  for (genvar k = 0; k < NUM_SIMD; k++) begin : g_lane_out
    assign SIMD_pointer[k*ADDR_WIDTH +: ADDR_WIDTH]       = r_simd_ptr[k];
    assign SIMD_g_arg_pointer[k*ADDR_WIDTH +: ADDR_WIDTH] = r_g_ptr[k];
    assign SIMD_l_arg_pointer[k*ADDR_WIDTH +: ADDR_WIDTH] = r_l_ptr[k];
  end

`ifdef TC_SCHED_PERF_EN
  logic [31:0] r_perf_busy;
  logic [31:0] r_perf_entries;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_busy    <= '0;
      r_perf_entries <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (r_state != ST_IDLE && ~&r_perf_busy) r_perf_busy <= r_perf_busy + 32'd1;
      if (w_dispatch && ~&r_perf_entries) r_perf_entries <= r_perf_entries + 32'd1;
      if (r_state == ST_SIMD_DISP && !w_grant_vld && ~&r_perf_stall)
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_busy_cycles  = r_perf_busy;
  assign perf_entries      = r_perf_entries;
  assign perf_stall_cycles = r_perf_stall;
`endif
endmodule

// File: tb/tb_tc_sched_fsm.sv
// tb/tb_tc_sched_fsm.sv - directed bench for tc_sched_fsm with an auto-responding MRA memory
module tb_tc_sched_fsm;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int LB = 8;
  localparam int NS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tc_sched_fsm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mra ();

  logic [AW-1:0]    PF_pointer;
  logic             PF_reset;
  logic             PF_done;
  logic [NS*AW-1:0] SIMD_pointer, SIMD_g_arg_pointer, SIMD_l_arg_pointer;
  logic [NS-1:0]    SIMD_reset;
  logic [NS-1:0]    SIMD_done;
  logic             SN_next_op;
  logic [AW-1:0]    SN_next_addr;
  logic [LB-1:0]    SN_next_len;
  logic             SN_clr_next;
  logic             SN_req_done;
`ifdef TC_SCHED_PERF_EN
  logic [31:0]      perf_busy_cycles, perf_entries, perf_stall_cycles;
`endif

  tc_sched_fsm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WL_LEN_BITS(LB), .NUM_SIMD(NS)) u_dut (
    .clk                (clk),
    .rst                (rst),
    .mra                (mra.master),
    .PF_pointer         (PF_pointer),
    .PF_reset           (PF_reset),
    .PF_done            (PF_done),
    .SIMD_pointer       (SIMD_pointer),
    .SIMD_g_arg_pointer (SIMD_g_arg_pointer),
    .SIMD_l_arg_pointer (SIMD_l_arg_pointer),
    .SIMD_reset         (SIMD_reset),
    .SIMD_done          (SIMD_done),
    .SN_next_op         (SN_next_op),
    .SN_next_addr       (SN_next_addr),
    .SN_next_len        (SN_next_len),
    .SN_clr_next        (SN_clr_next),
    .SN_req_done        (SN_req_done)
`ifdef TC_SCHED_PERF_EN
    ,
    .perf_busy_cycles   (perf_busy_cycles),
    .perf_entries       (perf_entries),
    .perf_stall_cycles  (perf_stall_cycles)
`endif
  );

  int            n_cmp = 0;
  int            n_err = 0;
  logic [AW-1:0] req_q[$];
  logic [AW-1:0] pf_val = '0;
  logic          pend = 1'b0;
  logic [AW-1:0] pend_addr = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Line for address a: pf field from pf_val, then a+0x100 / a+0x200 / a+0x300, upper bits all ones.
  function automatic logic [DW-1:0] line_for(input logic [AW-1:0] a);
    logic [DW-1:0] l;
    l = '1;
    l[AW-1:0]      = pf_val;
    l[2*AW-1:AW]   = a + 64'h100;
    l[3*AW-1:2*AW] = a + 64'h200;
    l[4*AW-1:3*AW] = a + 64'h300;
    return l;
  endfunction

  function automatic logic [AW-1:0] lane(input logic [NS*AW-1:0] v, input int k);
    return v[k*AW +: AW];
  endfunction

  // Memory: always ready, answers one cycle after the accepting edge.
  initial begin
    mra.MRA_ready     = 1'b1;
    mra.MRA_rsp_valid = 1'b0;
    mra.MRA_rsp_data  = '0;
    forever begin
      @(negedge clk);
      mra.MRA_rsp_valid = 1'b0;
      if (rst) pend = 1'b0;
      if (pend) begin
        mra.MRA_rsp_valid = 1'b1;
        mra.MRA_rsp_data  = line_for(pend_addr);
        pend = 1'b0;
      end
      if (mra.MRA_req_valid && mra.MRA_ready && !rst) begin
        pend      = 1'b1;
        pend_addr = mra.MRA_req_addr;
        req_q.push_back(mra.MRA_req_addr);
      end
    end
  end

  task automatic issue_op(input logic [AW-1:0] a, input logic [LB-1:0] n);
    SN_next_op   = 1'b1;
    SN_next_addr = a;
    SN_next_len  = n;
    @(negedge clk);
    SN_next_op = 1'b0;
    check_val("clr_pulse", 64'(SN_clr_next), 64'd1);
  endtask

  task automatic wait_mask(input string tag, input logic [NS-1:0] m);
    for (int c = 0; c < 60 && SIMD_reset !== m; c++) @(negedge clk);
    check_val(tag, 64'(SIMD_reset), 64'(m));
  endtask

  task automatic release_lanes(input logic [NS-1:0] m);
    SIMD_done = m;
    @(negedge clk);
    SIMD_done = '0;
  endtask

  task automatic wait_done(input string tag);
    for (int c = 0; c < 60 && !SN_req_done; c++) @(negedge clk);
    check_val(tag, 64'(SN_req_done), 64'd1);
    @(negedge clk);
  endtask

  task automatic wait_pf_run(input string tag);
    for (int c = 0; c < 60 && PF_reset; c++) @(negedge clk);
    check_val(tag, 64'(PF_reset), 64'd0);
  endtask

  int ndone;

  initial begin
    rst = 1'b1; PF_done = 1'b0; SIMD_done = '0;
    SN_next_op = 1'b0; SN_next_addr = '0; SN_next_len = '0;
    repeat (2) @(negedge clk);
    check_val("rst_simd_reset", 64'(SIMD_reset), 64'hF);
    check_val("rst_pf_reset", 64'(PF_reset), 64'd1);
    check_val("rst_req_valid", 64'(mra.MRA_req_valid), 64'd0);
    check_val("rst_req_addr", mra.MRA_req_addr, 64'd0);
    check_val("rst_rw", 64'(mra.MRA_rw), 64'd0);
    check_val("rst_clr", 64'(SN_clr_next), 64'd0);
    check_val("rst_done", 64'(SN_req_done), 64'd0);
    check_val("rst_pf_ptr", PF_pointer, 64'd0);
    check_val("rst_simd_ptr", 64'(|SIMD_pointer), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // len=0: done two cycles after clr, no fetch
    issue_op(64'h1000, 8'd0);
    @(negedge clk);
    check_val("len0_done_t1", 64'(SN_req_done), 64'd0);
    check_val("len0_no_req", 64'(mra.MRA_req_valid), 64'd0);
    @(negedge clk);
    check_val("len0_done_t2", 64'(SN_req_done), 64'd1);
    check_val("len0_req_cnt", 64'(req_q.size()), 64'd0);
    @(negedge clk);

    // len=3 at 0x1000, PF skipped: lanes 0,1,2
    issue_op(64'h1000, 8'd3);
    @(negedge clk);
    check_val("l3_req_valid", 64'(mra.MRA_req_valid), 64'd1);
    check_val("l3_req_addr", mra.MRA_req_addr, 64'h1000);
    repeat (2) @(negedge clk);
    check_val("l3_lane0_t3", 64'(SIMD_reset), 64'hE);
    check_val("l3_lane0_ptr", lane(SIMD_pointer, 0), 64'h1100);
    check_val("l3_lane0_g", lane(SIMD_g_arg_pointer, 0), 64'h1200);
    check_val("l3_lane0_l", lane(SIMD_l_arg_pointer, 0), 64'h1300);
    check_val("l3_pf_idle", 64'(PF_reset), 64'd1);
    wait_mask("l3_lane1", 4'hC);
    check_val("l3_lane1_ptr", lane(SIMD_pointer, 1), 64'h1140);
    wait_mask("l3_lane2", 4'h8);
    check_val("l3_lane2_l", lane(SIMD_l_arg_pointer, 2), 64'h1380);
    check_val("l3_req_cnt", 64'(req_q.size()), 64'd3);
    check_val("l3_req1", req_q[1], 64'h1040);
    check_val("l3_req2", req_q[2], 64'h1080);
    ndone = 0;
    repeat (5) begin @(negedge clk); if (SN_req_done) ndone++; end
    check_val("l3_drain_hold", 64'(ndone), 64'd0);
    release_lanes(4'h7);
    check_val("l3_lanes_idle", 64'(SIMD_reset), 64'hF);
    ndone = 0;
    repeat (6) begin @(negedge clk); if (SN_req_done) ndone++; end
    check_val("l3_done_once", 64'(ndone), 64'd1);
    req_q.delete();

    // len=6 at 0x2000 with done withheld: rr=3 so lanes 3,0,1,2 then stall
    issue_op(64'h2000, 8'd6);
    wait_mask("st_lane3", 4'h7);
    check_val("st_lane3_ptr", lane(SIMD_pointer, 3), 64'h2100);
    wait_mask("st_lane0", 4'h6);
    wait_mask("st_lane1", 4'h4);
    wait_mask("st_lane2", 4'h0);
    repeat (12) @(negedge clk);
    check_val("st_stalled", 64'(SIMD_reset), 64'h0);
    check_val("st_req_cnt", 64'(req_q.size()), 64'd5);
    release_lanes(4'h2);
    check_val("st_lane1_free", 64'(SIMD_reset), 64'h2);
    @(negedge clk);
    check_val("st_lane1_regrant", 64'(SIMD_reset), 64'h0);
    check_val("st_lane1_ptr", lane(SIMD_pointer, 1), 64'h2200);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      SIMD_done = ~SIMD_reset;
      @(negedge clk);
      if (SN_req_done) ndone++;
    end
    SIMD_done = '0;
    check_val("st_done_once", 64'(ndone), 64'd1);
    check_val("st_req_total", 64'(req_q.size()), 64'd6);
    check_val("st_req5", req_q[5], 64'h2140);
    req_q.delete();

    // PF path: entry 0x3000 with pf_ptr=0x5000; rr=3 -> lane3
    pf_val = 64'h5000;
    issue_op(64'h3000, 8'd1);
    wait_pf_run("pf_running");
    check_val("pf_ptr", PF_pointer, 64'h5000);
    repeat (3) @(negedge clk);
    check_val("pf_lanes_held", 64'(SIMD_reset), 64'hF);
    PF_done = 1'b1;
    @(negedge clk);
    PF_done = 1'b0;
    check_val("pf_reheld", 64'(PF_reset), 64'd1);
    check_val("pf_no_lane_yet", 64'(SIMD_reset), 64'hF);
    @(negedge clk);
    check_val("pf_lane3", 64'(SIMD_reset), 64'h7);
    check_val("pf_lane3_ptr", lane(SIMD_pointer, 3), 64'h3100);
    check_val("pf_lane3_g", lane(SIMD_g_arg_pointer, 3), 64'h3200);
    check_val("pf_lane3_l", lane(SIMD_l_arg_pointer, 3), 64'h3300);
    release_lanes(4'h8);
    wait_done("pf_done");
    req_q.delete();

    // Address wrap: second entry at 0x0
    pf_val = '0;
    issue_op(64'hFFFF_FFFF_FFFF_FFC0, 8'd2);
    wait_mask("wr_lane0", 4'hE);
    check_val("wr_lane0_ptr", lane(SIMD_pointer, 0), 64'hC0);
    wait_mask("wr_lane1", 4'hC);
    check_val("wr_lane1_ptr", lane(SIMD_pointer, 1), 64'h100);
    check_val("wr_lane1_l", lane(SIMD_l_arg_pointer, 1), 64'h300);
    check_val("wr_req0", req_q[0], 64'hFFFF_FFFF_FFFF_FFC0);
    check_val("wr_req1", req_q[1], 64'h0);
    release_lanes(4'hF);
    wait_done("wr_done");

    // Reset during PF_RUN, then a normal op from lane 0
    pf_val = 64'h7000;
    issue_op(64'h4000, 8'd1);
    wait_pf_run("rr_pf_running");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rr_pf_reset", 64'(PF_reset), 64'd1);
    check_val("rr_pf_ptr", PF_pointer, 64'd0);
    check_val("rr_simd_reset", 64'(SIMD_reset), 64'hF);
    check_val("rr_req_valid", 64'(mra.MRA_req_valid), 64'd0);
    check_val("rr_simd_ptr", 64'(|SIMD_pointer), 64'd0);
    ndone = 0;
    repeat (5) begin @(negedge clk); if (SN_req_done) ndone++; end
    check_val("rr_no_done", 64'(ndone), 64'd0);
    pf_val = '0;
    issue_op(64'h1000, 8'd1);
    wait_mask("rr_lane0", 4'hE);
    check_val("rr_lane0_ptr", lane(SIMD_pointer, 0), 64'h1100);
    release_lanes(4'h1);
    wait_done("rr_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench exceeded time limit");
    $fatal(1);
  end
endmodule
